fifo_byte_unpacker: RTL and testbench

Read-side consumer for the 34-bit clock-domain-crossing FIFO. It pops words through the FIFO read port (rdata/rempty/rinc) and streams 1–4 bytes per word on a valid/ready byte interface, running entirely in the FIFO read clock domain. Each FIFO word is 32 data bits plus a 2-bit byte count. A word holding fewer than 4 bytes marks end of frame.

---
 rtl/fifo_byte_unpacker_pkg.sv | 16 +
 rtl/fifo_byte_unpacker.sv | 78 +++++++
 tb/tb_fifo_byte_unpacker.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_byte_unpacker_pkg.sv
// Shared constants and state type for the FIFO byte unpacker.
// The FIFO word carries a 32-bit payload with a 2-bit "byte count minus one" field above it.
package fifo_byte_unpacker_pkg;

    localparam int NBYTES      = 4;
    localparam int FIFO_DSIZE  = 34;
    localparam int PAYLOAD_MSB = 31;
    localparam int CNT_LSB     = 32;
    localparam int CNT_MSB     = 33;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_byte_unpacker.sv
// Pops 34-bit words from the CDC FIFO read port and streams 1-4 bytes per word on a
// valid/ready byte interface. A word with fewer than four bytes ends a frame.
module fifo_byte_unpacker
    import fifo_byte_unpacker_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [FIFO_DSIZE-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    state_t                  r_state;
    logic [FIFO_DSIZE-1:0]   r_hold;
    logic [1:0]              r_idx;
    logic [CNT_WIDTH-1:0]    r_word_cnt;
    logic [CNT_WIDTH-1:0]    r_frame_cnt;

    logic [1:0]              w_nb;
    logic [1:0]              w_sel;
    logic [PAYLOAD_MSB:0]    w_payload;
    logic                    w_hold_valid;
    logic                    w_acc;
    logic                    w_done;
    logic                    w_pop;

    assign w_hold_valid = (r_state == HOLD);
    assign w_nb         = r_hold[CNT_MSB:CNT_LSB];
    assign w_payload    = r_hold[PAYLOAD_MSB:0];
    assign w_acc        = w_hold_valid & out_ready;
    assign w_done       = w_acc & (r_idx == w_nb);

    // A new word may be fetched in the same cycle the last byte of the current one is taken,
    // which is what gives gap-free streaming across word boundaries.
    assign w_pop        = rst_n & enable & ~fifo_rempty & (~w_hold_valid | w_done);
    assign fifo_rinc    = w_pop;

    assign w_sel        = MSB_FIRST ? (2'(NBYTES - 1) - r_idx) : r_idx;
    assign out_data     = w_payload[{w_sel, 3'b000} +: 8];
    assign out_valid    = w_hold_valid;
    assign out_last     = w_hold_valid & (r_idx == w_nb) & (w_nb != 2'd3);
    assign word_cnt     = r_word_cnt;
    assign frame_cnt    = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_hold      <= '0;
            r_idx       <= 2'd0;
            r_word_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_pop) begin
            r_state    <= HOLD;
            r_hold     <= fifo_rdata;
            r_idx      <= 2'd0;
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            if (fifo_rdata[CNT_MSB:CNT_LSB] != 2'd3) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end
        end else if (w_done) begin
            r_state <= EMPTY;
            r_idx   <= 2'd0;
        end else if (w_acc) begin
            r_idx <= r_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Directed self-checking bench for fifo_byte_unpacker: LSB-first instance fed by a queue FIFO
// model, plus an MSB-first instance with narrow counters driven by hand.
module tb_fifo_byte_unpacker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [33:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] word_cnt;
    logic [15:0] frame_cnt;

    logic        m_enable;
    logic [33:0] m_rdata;
    logic        m_rempty;
    logic        m_rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [1:0]  m_word_cnt;
    logic [1:0]  m_frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [33:0] fq[$];

    fifo_byte_unpacker #(.MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .word_cnt(word_cnt), .frame_cnt(frame_cnt)
    );

    fifo_byte_unpacker #(.MSB_FIRST(1'b1), .CNT_WIDTH(2)) dutMsb (
        .clk(clk), .rst_n(rst_n), .enable(m_enable),
        .fifo_rdata(m_rdata), .fifo_rempty(m_rempty), .fifo_rinc(m_rinc),
        .out_data(m_data), .out_valid(m_valid), .out_ready(m_ready),
        .out_last(m_last), .word_cnt(m_word_cnt), .frame_cnt(m_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read side of the FIFO: empty flag and read data are registered, and advance on a pop.
    always @(posedge clk) begin
        if (fifo_rinc && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        fifo_rempty <= (fq.size() == 0);
        fifo_rdata  <= (fq.size() > 0) ? fq[0] : 34'd0;
    end

    task automatic pushWord(input logic [33:0] w);
        fq.push_back(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
        m_enable = 1'b1; m_ready = 1'b1; m_rempty = 1'b1; m_rdata = '0;
        @(negedge clk);
        pushWord(34'h3_12345678);
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_data, out_last} !== 10'd0) begin
            errors++; $display("[TB] FAIL reset_out got v/d/l=%b/%h/%b want 0/00/0", out_valid, out_data, out_last);
        end
        checks++;
        if ({word_cnt, frame_cnt} !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", word_cnt, frame_cnt);
        end
        checks++;
        if (fifo_rinc !== 1'b0 || fifo_rempty !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rinc got rinc=%b (rempty=%b) want 0 with rempty 0", fifo_rinc, fifo_rempty);
        end
        fq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_rinc !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release got v=%b rinc=%b want 0/0", out_valid, fifo_rinc);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pushWord(34'h3_DDCCBBAA);
        @(negedge clk); #1;
        checks++;
        if (fifo_rinc !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_pop got rinc=%b v=%b want 1/0", fifo_rinc, out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({out_valid, out_data, out_last} !== {1'b1, exp[k], 1'b0}) begin
                errors++; $display("[TB] FAIL single_byte%0d got v/d/l=%b/%h/%b want 1/%h/0", k, out_valid, out_data, out_last, exp[k]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd1 || frame_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL single_end got v=%b cnt=%0d/%0d want 0 1/0", out_valid, word_cnt, frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pushWord(34'h3_44332211);
        pushWord(34'h1_00006655);
        @(negedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({out_valid, out_data, out_last} !== {1'b1, exp[k], (k == 5)}) begin
                errors++; $display("[TB] FAIL b2b_byte%0d got v/d/l=%b/%h/%b want 1/%h/%b", k, out_valid, out_data, out_last, exp[k], (k == 5));
            end
            if (k == 3) begin
                checks++;
                if (fifo_rinc !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_rinc got %b want 1", fifo_rinc);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd3 || frame_cnt !== 16'd1) begin
            errors++; $display("[TB] FAIL b2b_end got v=%b cnt=%0d/%0d want 0 3/1", out_valid, word_cnt, frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pushWord(34'h3_44332211);
        pushWord(34'h3_88776655);
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp[k]}) begin
                errors++; $display("[TB] FAIL bp_pre%0d got v/d=%b/%h want 1/%h", k, out_valid, out_data, exp[k]);
            end
        end
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_data, fifo_rinc} !== {1'b1, 8'h33, 1'b0}) begin
                errors++; $display("[TB] FAIL bp_hold%0d got v/d/rinc=%b/%h/%b want 1/33/0", i, out_valid, out_data, fifo_rinc);
            end
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        for (int k = 2; k < 8; k++) begin
            checks++;
            if ({out_valid, out_data, out_last} !== {1'b1, exp[k], 1'b0}) begin
                errors++; $display("[TB] FAIL bp_post%0d got v/d/l=%b/%h/%b want 1/%h/0", k, out_valid, out_data, out_last, exp[k]);
            end
            if (k == 3) begin
                checks++;
                if (fifo_rinc !== 1'b1) begin
                    errors++; $display("[TB] FAIL bp_rinc got %b want 1", fifo_rinc);
                end
            end
            @(negedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd5 || frame_cnt !== 16'd1) begin
            errors++; $display("[TB] FAIL bp_end got v=%b cnt=%0d/%0d want 0 5/1", out_valid, word_cnt, frame_cnt);
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (fifo_rinc !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL empty_idle%0d got rinc=%b v=%b want 0/0", i, fifo_rinc, out_valid);
            end
        end
        pushWord(34'h0_000000EE);
        @(negedge clk); #1;
        checks++;
        if (fifo_rinc !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL empty_pop got rinc=%b v=%b want 1/0", fifo_rinc, out_valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_data, out_last, fifo_rinc} !== {1'b1, 8'hEE, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL empty_byte got v/d/l/rinc=%b/%h/%b/%b want 1/ee/1/0", out_valid, out_data, out_last, fifo_rinc);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd6 || frame_cnt !== 16'd2) begin
            errors++; $display("[TB] FAIL empty_end got v=%b cnt=%0d/%0d want 0 6/2", out_valid, word_cnt, frame_cnt);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] exp[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pushWord(34'h3_DDCCBBAA);
        pushWord(34'h3_11111111);
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (k == 1) enable = 1'b0;
            #1;
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp[k]}) begin
                errors++; $display("[TB] FAIL en_byte%0d got v/d=%b/%h want 1/%h", k, out_valid, out_data, exp[k]);
            end
            if (k == 3) begin
                checks++;
                if (fifo_rinc !== 1'b0) begin
                    errors++; $display("[TB] FAIL en_nopop got rinc=%b want 0", fifo_rinc);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || fifo_rinc !== 1'b0) begin
                errors++; $display("[TB] FAIL en_idle%0d got v=%b rinc=%b want 0/0", i, out_valid, fifo_rinc);
            end
        end
        enable = 1'b1;
        #1;
        checks++;
        if (fifo_rinc !== 1'b1) begin
            errors++; $display("[TB] FAIL en_rise got rinc=%b want 1", fifo_rinc);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
                errors++; $display("[TB] FAIL en_resume%0d got v/d=%b/%h want 1/11", k, out_valid, out_data);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd8 || frame_cnt !== 16'd2) begin
            errors++; $display("[TB] FAIL en_end got v=%b cnt=%0d/%0d want 0 8/2", out_valid, word_cnt, frame_cnt);
        end
    endtask

    task automatic test_reset_midword();
        pushWord(34'h3_AABBCCDD);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'hCC}) begin
            errors++; $display("[TB] FAIL rst_mid_pre got v/d=%b/%h want 1/cc", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_last, fifo_rinc} !== 11'd0 || {word_cnt, frame_cnt} !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_mid got v/d/l/rinc=%b/%h/%b/%b cnt=%0d/%0d want all 0",
                               out_valid, out_data, out_last, fifo_rinc, word_cnt, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_rinc !== 1'b0 || word_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL rst_mid_after got v=%b rinc=%b cnt=%0d want 0/0/0", out_valid, fifo_rinc, word_cnt);
        end
    endtask

    // expB lists the expected bytes in emission order, first byte in [31:24].
    task automatic msbWord(input logic [33:0] w, input logic [31:0] expB, input int n,
                           input logic [1:0] expWords, input logic [1:0] expFrames);
        logic [7:0] eb;
        m_rdata = w; m_rempty = 1'b0;
        #1;
        checks++;
        if (m_rinc !== 1'b1) begin
            errors++; $display("[TB] FAIL msb_pop %h got rinc=%b want 1", w, m_rinc);
        end
        @(negedge clk);
        m_rempty = 1'b1; m_rdata = '0;
        #1;
        for (int k = 0; k < n; k++) begin
            eb = expB[31 - 8*k -: 8];
            checks++;
            if ({m_valid, m_data, m_last} !== {1'b1, eb, (k == n - 1) && (w[33:32] != 2'd3)}) begin
                errors++; $display("[TB] FAIL msb_byte %h/%0d got v/d/l=%b/%h/%b want 1/%h/%b",
                                   w, k, m_valid, m_data, m_last, eb, (k == n - 1) && (w[33:32] != 2'd3));
            end
            @(negedge clk); #1;
        end
        checks++;
        if (m_valid !== 1'b0 || m_word_cnt !== expWords || m_frame_cnt !== expFrames) begin
            errors++; $display("[TB] FAIL msb_end %h got v=%b cnt=%0d/%0d want 0 %0d/%0d",
                               w, m_valid, m_word_cnt, m_frame_cnt, expWords, expFrames);
        end
    endtask

    task automatic test_msb_first();
        @(negedge clk);
        msbWord(34'h0_000000AB, 32'h00_000000, 1, 2'd1, 2'd1);
        msbWord(34'h3_DDCCBBAA, 32'hDDCCBBAA, 4, 2'd2, 2'd1);
        msbWord(34'h0_12345678, 32'h12_000000, 1, 2'd3, 2'd2);
        msbWord(34'h2_00C0FFEE, 32'h00C0FF_00, 3, 2'd0, 2'd3);
        msbWord(34'h1_ABCD0000, 32'hABCD_0000, 2, 2'd1, 2'd0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_enable_drop();
        test_reset_midword();
        test_msb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
